// File: rtl/hdlc_tx_fifo.sv
// HDLC-style serial transmitter: CPU-side transmit FIFO feeding a line FSM
// that idles on flags and inserts a 0 after every run of five 1s in data.
module hdlc_tx_fifo #(
  parameter int          DW    = 8,
  parameter int          DEPTH = 4,
  parameter logic [7:0]  FLAG  = 8'h7E
) (
  input  logic                     CLK2M,
  input  logic                     RESET,
  input  logic [DW-1:0]            D,
  input  logic                     CS,
  input  logic                     WR,
  input  logic                     A0,
  input  logic                     FS,
  output logic                     TxD,
  output logic                     FULL,
  output logic                     EMPTY,
  output logic [$clog2(DEPTH):0]   LEVEL,
  output logic                     OVF,
  output logic                     BUSY
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DW + 1);
  localparam logic [AW:0]   LVL_FULL = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(DW);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  typedef enum logic [0:0] {ST_FLAG = 1'b0, ST_DATA = 1'b1} line_state_t;

  // FIFO and control register state
  logic [DW-1:0]  mem_r [DEPTH];
  logic [AW-1:0]  wr_ptr_r;
  logic [AW-1:0]  rd_ptr_r;
  logic [AW:0]    level_r;
  logic           full_r;
  logic           empty_r;
  logic           ovf_r;
  logic           tx_en_r;

  // Line FSM state
  line_state_t    state_r;
  logic [2:0]     bit_idx_r;
  logic [2:0]     ones_r;
  logic [CW-1:0]  cnt_r;
  logic [DW-1:0]  shift_r;
  logic           txd_r;
  logic           busy_r;

  // Decoded strobes
  logic           data_wr_s;
  logic           ctl_wr_s;
  logic           push_s;
  logic           pop_s;
  logic           last_s;
  logic           stuff_s;
  logic [AW:0]    level_nxt_s;
  logic [DW-1:0]  head_s;

  assign data_wr_s = CS & WR & ~A0;
  assign ctl_wr_s  = CS & WR & A0;
  // Full check is on the registered flag: a write is dropped even if a pop frees a slot this cycle.
  assign push_s    = data_wr_s & ~full_r;
  assign head_s    = mem_r[rd_ptr_r];
  assign stuff_s   = (ones_r == 3'd5);

  // Decide whether this FS cycle ends a word/flag and whether it pops the FIFO head.
  always_comb begin
    pop_s  = 1'b0;
    last_s = 1'b0;
    if (FS) begin
      if (state_r == ST_FLAG) begin
        pop_s = (bit_idx_r == 3'd0) & tx_en_r & ~empty_r;
      end else begin
        if (stuff_s) begin
          // A stuff pending after the final data bit closes the word here.
          last_s = (cnt_r == CNT_ZERO);
        end else begin
          // The final bit ends the word unless it completes a run of five ones.
          last_s = (cnt_r == CNT_ONE) & ~(shift_r[DW-1] & (ones_r == 3'd4));
        end
        pop_s = last_s & ~empty_r;
      end
    end else begin
      pop_s  = 1'b0;
      last_s = 1'b0;
    end
  end

  // Next FIFO occupancy from this cycle's push/pop pair.
  always_comb begin
    case ({push_s, pop_s})
      2'b10:   level_nxt_s = level_r + {{AW{1'b0}}, 1'b1};
      2'b01:   level_nxt_s = level_r - {{AW{1'b0}}, 1'b1};
      default: level_nxt_s = level_r;
    endcase
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge CLK2M) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= D;
    end
  end

  // FIFO pointers, occupancy flags, overflow flag and transmit enable.
  always_ff @(posedge CLK2M) begin
    if (RESET) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {(AW + 1){1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
      ovf_r    <= 1'b0;
      tx_en_r  <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + {{(AW - 1){1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(AW - 1){1'b0}}, 1'b1};
      end
      level_r <= level_nxt_s;
      full_r  <= (level_nxt_s == LVL_FULL);
      empty_r <= (level_nxt_s == {(AW + 1){1'b0}});
      if (data_wr_s & full_r) begin
        ovf_r <= 1'b1;
      end else if (ctl_wr_s & D[1]) begin
        ovf_r <= 1'b0;
      end
      if (ctl_wr_s) begin
        tx_en_r <= D[0];
      end
    end
  end

  // Line FSM: one line bit per FS cycle, flags when idle, zero-stuffing in data.
  always_ff @(posedge CLK2M) begin
    if (RESET) begin
      state_r   <= ST_FLAG;
      bit_idx_r <= 3'd7;
      ones_r    <= 3'd0;
      cnt_r     <= CNT_ZERO;
      shift_r   <= {DW{1'b0}};
      txd_r     <= 1'b1;
      busy_r    <= 1'b0;
    end else if (FS) begin
      case (state_r)
        ST_FLAG: begin
          txd_r  <= FLAG[bit_idx_r];
          ones_r <= 3'd0;
          if (bit_idx_r == 3'd0) begin
            bit_idx_r <= 3'd7;
            if (pop_s) begin
              shift_r <= head_s;
              cnt_r   <= CNT_LOAD;
              state_r <= ST_DATA;
              busy_r  <= 1'b1;
            end
          end else begin
            bit_idx_r <= bit_idx_r - 3'd1;
          end
        end
        ST_DATA: begin
          if (stuff_s) begin
            txd_r  <= 1'b0;
            ones_r <= 3'd0;
          end else begin
            txd_r   <= shift_r[DW-1];
            shift_r <= {shift_r[DW-2:0], 1'b0};
            cnt_r   <= cnt_r - CNT_ONE;
            ones_r  <= shift_r[DW-1] ? (ones_r + 3'd1) : 3'd0;
          end
          if (last_s) begin
            if (pop_s) begin
              // Next word follows directly; the ones run carries across the boundary.
              shift_r <= head_s;
              cnt_r   <= CNT_LOAD;
            end else begin
              state_r   <= ST_FLAG;
              bit_idx_r <= 3'd7;
              busy_r    <= 1'b0;
            end
          end
        end
        default: begin
          state_r   <= ST_FLAG;
          bit_idx_r <= 3'd7;
          ones_r    <= 3'd0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  assign TxD   = txd_r;
  assign FULL  = full_r;
  assign EMPTY = empty_r;
  assign LEVEL = level_r;
  assign OVF   = ovf_r;
  assign BUSY  = busy_r;

endmodule

// File: tb/tb_hdlc_tx_fifo.sv
// Self-checking bench for hdlc_tx_fifo: queue-based line/FIFO model checked
// every cycle, plus literal line-bit sequences for the directed scenarios.
module tb_hdlc_tx_fifo;

  localparam int         DW    = 8;
  localparam int         DEPTH = 4;
  localparam logic [7:0] FLAGV = 8'h7E;

  logic       CLK2M = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] D     = 8'h00;
  logic       CS    = 1'b0;
  logic       WR    = 1'b0;
  logic       A0    = 1'b0;
  logic       FS    = 1'b0;
  logic       TxD;
  logic       FULL;
  logic       EMPTY;
  logic [2:0] LEVEL;
  logic       OVF;
  logic       BUSY;

  hdlc_tx_fifo #(.DW(DW), .DEPTH(DEPTH), .FLAG(FLAGV)) dut (
    .CLK2M(CLK2M), .RESET(RESET), .D(D), .CS(CS), .WR(WR), .A0(A0), .FS(FS),
    .TxD(TxD), .FULL(FULL), .EMPTY(EMPTY), .LEVEL(LEVEL), .OVF(OVF), .BUSY(BUSY)
  );

  always #5 CLK2M = ~CLK2M;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state
  logic [7:0] m_q[$];
  bit         m_bits[$];
  int         m_run = 0;
  int         m_flag_pos = 0;
  bit         m_in_data = 1'b0;
  bit         m_txen = 1'b0;
  bit         m_ovf = 1'b0;
  bit         m_busy = 1'b0;
  bit         m_txd = 1'b1;
  bit         chk_en = 1'b0;
  bit         fs_edge = 1'b0;
  bit         cap[$];

  function automatic void load_word();
    logic [7:0] w;
    w = m_q.pop_front();
    m_bits.delete();
    for (int i = DW - 1; i >= 0; i--) m_bits.push_back(w[i]);
  endfunction

  // Model: advance line and FIFO on each rising edge from the sampled inputs.
  always @(posedge CLK2M) begin
    int old_size;
    bit b;
    logic [7:0] fl;
    fs_edge = FS && !RESET;
    if (RESET) begin
      m_q.delete(); m_bits.delete();
      m_run = 0; m_flag_pos = 0; m_in_data = 0; m_txen = 0;
      m_ovf = 0; m_busy = 0; m_txd = 1; chk_en = 1;
    end else begin
      old_size = m_q.size();
      fl = FLAGV;
      if (FS) begin
        if (!m_in_data) begin
          m_txd = fl[7 - m_flag_pos];
          m_run = 0;
          if (m_flag_pos == 7) begin
            m_flag_pos = 0;
            if (m_txen && old_size > 0) begin
              load_word(); m_in_data = 1; m_busy = 1;
            end
          end else begin
            m_flag_pos++;
          end
        end else begin
          if (m_run == 5) begin
            m_txd = 0; m_run = 0;
          end else begin
            b = m_bits.pop_front();
            m_txd = b;
            m_run = b ? m_run + 1 : 0;
          end
          if (m_bits.size() == 0 && m_run != 5) begin
            if (old_size > 0) load_word();
            else begin
              m_in_data = 0; m_flag_pos = 0; m_busy = 0;
            end
          end
        end
      end
      if (CS && WR) begin
        if (A0) begin
          m_txen = D[0];
          if (D[1]) m_ovf = 0;
        end else if (old_size < DEPTH) begin
          m_q.push_back(D);
        end else begin
          m_ovf = 1;
        end
      end
    end
  end

  // Compare all outputs against the model every cycle; log line bits on FS cycles.
  always @(negedge CLK2M) begin
    logic [2:0] el;
    if (chk_en) begin
      el = 3'(m_q.size());
      n_cmp++;
      if (TxD !== m_txd || LEVEL !== el || FULL !== (m_q.size() == DEPTH) ||
          EMPTY !== (m_q.size() == 0) || OVF !== m_ovf || BUSY !== m_busy) begin
        n_bad++;
        $display("FAIL cycle t=%0t got txd=%b lvl=%0d full=%b empty=%b ovf=%b busy=%b expected txd=%b lvl=%0d full=%b empty=%b ovf=%b busy=%b",
                 $time, TxD, LEVEL, FULL, EMPTY, OVF, BUSY, m_txd, el,
                 m_q.size() == DEPTH, m_q.size() == 0, m_ovf, m_busy);
      end
      if (fs_edge) cap.push_back(TxD);
    end
  end

  task automatic step(input logic cs, input logic wr, input logic a0,
                      input logic [7:0] d, input logic fs);
    @(negedge CLK2M);
    CS = cs; WR = wr; A0 = a0; D = d; FS = fs;
  endtask

  task automatic do_reset();
    @(negedge CLK2M);
    RESET = 1'b1; CS = 1'b0; WR = 1'b0; A0 = 1'b0; D = 8'h00; FS = 1'b0;
    @(negedge CLK2M);
    RESET = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic bit has_pat(input logic [63:0] pat, input int len);
    for (int s = 0; s + len <= cap.size(); s++) begin
      bit ok = 1'b1;
      for (int k = 0; k < len; k++) if (cap[s + k] != pat[len - 1 - k]) ok = 1'b0;
      if (ok) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic chk_pat(input string name, input logic [63:0] pat, input int len);
    n_cmp++;
    if (!has_pat(pat, len)) begin
      n_bad++;
      $display("FAIL %s line sequence %0d bits got=%0d logged bits, expected pattern %0h not found",
               name, len, cap.size(), pat);
    end
  endtask

  task automatic run_fs(input int n, input logic fs);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00, fs);
  endtask

  initial begin
    logic [7:0] d;
    logic       a0;
    logic [15:0] two_flags;

    // Reset state and continuous flags with TX_EN=0
    do_reset();
    chk("rst_txd", {31'd0, TxD}, 32'd1);
    chk("rst_level", {29'd0, LEVEL}, 32'd0);
    chk("rst_empty", {31'd0, EMPTY}, 32'd1);
    chk("rst_busy", {31'd0, BUSY}, 32'd0);
    cap.delete();
    run_fs(16, 1'b1);
    run_fs(2, 1'b0);
    two_flags = 16'h0000;
    for (int i = 0; i < 16 && i < cap.size(); i++) two_flags[15 - i] = cap[i];
    chk("idle_len", cap.size(), 32'd16);
    chk("idle_flags", {16'd0, two_flags}, 32'h7E7E);

    // Single word 0xA5, no stuffing
    do_reset();
    cap.delete();
    run_fs(8, 1'b1);
    step(1'b1, 1'b1, 1'b0, 8'hA5, 1'b1);
    step(1'b1, 1'b1, 1'b1, 8'h01, 1'b1);
    run_fs(40, 1'b1);
    run_fs(2, 1'b0);
    chk_pat("a5_frame", {40'd0, 8'h7E, 8'hA5, 8'h7E}, 24);
    chk("a5_level", {29'd0, LEVEL}, 32'd0);
    chk("a5_busy", {31'd0, BUSY}, 32'd0);

    // 0xFF with a stuffed zero after the fifth one
    do_reset();
    cap.delete();
    run_fs(4, 1'b1);
    step(1'b1, 1'b1, 1'b0, 8'hFF, 1'b1);
    step(1'b1, 1'b1, 1'b1, 8'h01, 1'b1);
    run_fs(40, 1'b1);
    run_fs(2, 1'b0);
    chk_pat("ff_stuff", {39'd0, 8'h7E, 9'b111110111, 8'h7E}, 25);

    // Stuff spanning a word boundary, no flag between words
    do_reset();
    cap.delete();
    run_fs(3, 1'b1);
    step(1'b1, 1'b1, 1'b0, 8'h1F, 1'b1);
    step(1'b1, 1'b1, 1'b0, 8'hF8, 1'b1);
    step(1'b1, 1'b1, 1'b1, 8'h01, 1'b1);
    run_fs(50, 1'b1);
    run_fs(2, 1'b0);
    chk_pat("span_stuff", {30'd0, 8'h7E, 18'b000111110111110000, 8'h7E}, 34);

    // Overflow with TX_EN=0, OVF clear, contents intact
    do_reset();
    step(1'b1, 1'b1, 1'b0, 8'h11, 1'b0);
    step(1'b1, 1'b1, 1'b0, 8'h22, 1'b0);
    step(1'b1, 1'b1, 1'b0, 8'h33, 1'b0);
    step(1'b1, 1'b1, 1'b0, 8'h44, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("ovf_full", {31'd0, FULL}, 32'd1);
    chk("ovf_level4", {29'd0, LEVEL}, 32'd4);
    chk("ovf_pre", {31'd0, OVF}, 32'd0);
    step(1'b1, 1'b1, 1'b0, 8'h55, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("ovf_set", {31'd0, OVF}, 32'd1);
    chk("ovf_level_hold", {29'd0, LEVEL}, 32'd4);
    step(1'b1, 1'b1, 1'b1, 8'h02, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("ovf_clear", {31'd0, OVF}, 32'd0);
    chk("ovf_full_hold", {31'd0, FULL}, 32'd1);
    cap.delete();
    step(1'b1, 1'b1, 1'b1, 8'h01, 1'b1);
    run_fs(80, 1'b1);
    run_fs(2, 1'b0);
    chk_pat("ovf_contents", {16'd0, 8'h7E, 8'h11, 8'h22, 8'h33, 8'h44, 8'h7E}, 48);
    chk("ovf_drained", {31'd0, EMPTY}, 32'd1);

    // FS 1-in-4, reset mid-word
    do_reset();
    step(1'b1, 1'b1, 1'b0, 8'hA5, 1'b0);
    step(1'b1, 1'b1, 1'b1, 8'h01, 1'b0);
    for (int i = 0; i < 48; i++) step(1'b0, 1'b0, 1'b0, 8'h00, (i % 4) == 0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("slow_busy", {31'd0, BUSY}, 32'd1);
    chk("slow_popped", {29'd0, LEVEL}, 32'd0);
    do_reset();
    chk("mid_rst_txd", {31'd0, TxD}, 32'd1);
    chk("mid_rst_busy", {31'd0, BUSY}, 32'd0);
    chk("mid_rst_level", {29'd0, LEVEL}, 32'd0);
    cap.delete();
    step(1'b1, 1'b1, 1'b0, 8'h3C, 1'b1);
    run_fs(15, 1'b1);
    run_fs(2, 1'b0);
    two_flags = 16'h0000;
    for (int i = 0; i < 16 && i < cap.size(); i++) two_flags[15 - i] = cap[i];
    chk("post_rst_flags", {16'd0, two_flags}, 32'h7E7E);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        a0 = ($urandom_range(0, 5) == 0);
        d  = 8'($urandom);
        if (a0) begin
          d[0] = ($urandom_range(0, 4) != 0);
          d[1] = ($urandom_range(0, 7) == 0);
        end else if ($urandom_range(0, 2) == 0) begin
          d = 8'hFF;
        end
        step($urandom_range(0, 3) == 0, 1'b1, a0, d, $urandom_range(0, 3) != 0);
      end
    end
    run_fs(2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hdlc_tx_fifo.md
# hdlc_tx_fifo

Parametrised HDLC-style serial transmitter with a configurable-depth transmit FIFO, continuous flag idling and zero-bit stuffing. The CPU side writes data words and a control register over the CS/WR/A0 bus; the line side shifts one bit per FS strobe onto TxD. It is the next-generation line transmitter in the serial datapath, clocked from CLK2M.

## Interface
- DW, 8: data word width in bits (≥2); the flag is always 8 bits.
- DEPTH, 4: FIFO depth in words, power of two, ≥2.
- FLAG, 8'h7E: flag/idle pattern, sent MSB first.
- Clock and reset: one clock, CLK2M; reset is RESET, synchronous and active-high.
- CLK2M  in  1  system clock; all logic on the rising edge.
- RESET  in  1  synchronous active-high reset.
- D  in  DW  CPU write data.
- CS  in  1  chip select.
- WR  in  1  write strobe, one word per cycle with CS&WR high.
- A0  in  1  address: 0 = data FIFO, 1 = control register.
- FS  in  1  bit-enable strobe; the line advances one bit on each cycle with FS=1.
- TxD  out  1  serial line, registered.
- FULL  out  1  FIFO holds DEPTH words.
- EMPTY  out  1  FIFO holds 0 words.
- LEVEL  out  log2(DEPTH)+1  FIFO occupancy.
- OVF  out  1  sticky overflow flag.
- BUSY  out  1  high while in DATA state.

## Operation
- Data write: CS&WR&~A0 pushes D when FULL=0. If FULL=1, D is dropped and OVF is set. The full check uses the registered FULL, so a write is dropped even when a pop occurs in the same cycle.
- Control write: CS&WR&A0 loads TX_EN=D[0]. D[1]=1 clears OVF.
- FIFO: circular, with read and write pointers of log2(DEPTH) bits that wrap modulo DEPTH. A push and a pop in the same cycle leave LEVEL unchanged.
- Line FSM states: FLAG and DATA. All state, counter and TxD updates happen only on cycles with FS=1. With FS=0 everything holds.
- FLAG: shifts FLAG MSB first, bits 7..0, with no stuffing. The ones-run counter is cleared on every flag bit.
  - On the FS cycle that outputs flag bit 0: if TX_EN=1 and EMPTY=0, pop the head into the shift register, set bit count to DW and go to DATA.
  - Otherwise restart FLAG, giving continuous flags.
- DATA: each FS cycle outputs one bit.
  - If the ones-run counter equals 5, output a stuffed 0, clear the counter and consume no data bit.
  - Otherwise output the shift-register MSB, shift left, decrement the bit count, and update the counter (increment on 1, clear on 0).
- After the last data bit (count reaches 0, and no stuff pending from a counter that is not yet 5):
  - If EMPTY=0, pop the next word and stay in DATA, with no flag between words.
  - Else go to FLAG; this closing flag doubles as the idle flag.
- Stuff after the final bit: if the last data bit brings the counter to 5, the stuffed 0 is sent before leaving DATA.
- TX_EN=0 during DATA does not abort; the current frame drains until the FIFO is empty.
- Reset: FIFO empty (LEVEL=0, EMPTY=1, FULL=0), OVF=0, TX_EN=0, state FLAG at bit 7, ones counter 0, TxD=1, BUSY=0.

## Timing
- Write at edge n: LEVEL, FULL and EMPTY reflect it after edge n (visible in cycle n+1).
- TxD changes only after an edge at which FS=1; each FS cycle drives exactly one line bit.
- First TxD bit after reset: FLAG bit 7 (0), on the first FS cycle.
- Pop occurs on the same edge as the last bit of the flag or word. The first bit of the popped word appears on the next FS edge, with no idle bit in between.
- Latency, with FS held high: FIFO write to first data bit is at most 8 + 1 flag-bit cycles after TX_EN=1.
- BUSY is high from the pop edge into DATA until the edge that enters FLAG.
- RESET asserted mid-frame: takes effect at the next edge regardless of FS. The partial frame is abandoned and TxD returns to 1 and then to flags.

## Test plan
- Reset, FS=1 continuous, TX_EN=0 -> TxD repeats 01111110; LEVEL=0, BUSY=0.
- Write 0xA5, then control write 0x01 -> after the current flag ends, TxD = 10100101 then 01111110; no stuffed bits; LEVEL returns to 0 on the pop edge.
- Write 0xFF, TX_EN=1 -> TxD = 11111 0 111, then flag 01111110; the stuffed 0 occurs after the 5th one.
- Write 0x1F, then 0xF8 back-to-back -> TxD = 00011111 0 11111 0 000, then flag; the stuff spans the word boundary and no flag appears between the words.
- DEPTH=4, TX_EN=0, write 5 words -> FULL=1 after the 4th write, the 5th is dropped and OVF=1; control write 0x02 clears OVF; the FIFO contents are unchanged.
- FS toggled 1-in-4 during a frame, with RESET asserted mid-word -> TxD advances only on FS cycles; after reset TxD=1, LEVEL=0, TX_EN=0, and flags resume.
